// File: rtl/attrib_case_map_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : attrib_case_map_pipe
//  Description : Maps a WIDTH-bit code through one of four selectable
//                mappings (complement, identity, binary-to-Gray, programmable
//                lookup table). The result sits in a single output register
//                behind a valid/ready handshake with backpressure. A wrapping
//                counter records completed output transfers.
//
//  Ports       : clk        - sole clock, rising edge
//                rst        - asynchronous, active-low reset
//                mode       - mapping select, sampled with the code on accept
//                             (0 complement, 1 identity, 2 Gray, 3 LUT)
//                in_valid   - input code valid
//                in_ready   - block can accept a code this cycle
//                inp        - input code
//                out_valid  - output register holds a valid result
//                out_ready  - consumer accepts the result
//                out        - mapped result
//                wr_en      - LUT write strobe
//                wr_addr    - LUT write index
//                wr_data    - LUT write value
//                xfer_cnt   - completed output transfers (wraps silently)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module attrib_case_map_pipe #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int         c_depth     = 1 << WIDTH;
  localparam logic [1:0] c_mode_cmp  = 2'd0;
  localparam logic [1:0] c_mode_id   = 2'd1;
  localparam logic [1:0] c_mode_gray = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] lut_q [c_depth];
  logic [WIDTH-1:0] lut_d [c_depth];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q,       out_d;
  logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;

  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mapped;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The output register can take a new code whenever it is empty or is being
  // emptied in this same cycle, which gives full throughput back-to-back.
  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid_q && out_ready;

  // --------------------------------------------------------------------------
  // Mapping. The LUT is read from the registered array, so a write landing in
  // the same cycle as a mode-3 accept to the same index returns the old entry.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mapped = lut_q[inp];
    case (mode)
      c_mode_cmp:  w_mapped = ~inp;
      c_mode_id:   w_mapped = inp;
      c_mode_gray: w_mapped = inp ^ (inp >> 1);
      default:     w_mapped = lut_q[inp];
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    lut_d = lut_q;
    if (wr_en) begin
      lut_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_d       = w_mapped;
    end else if (w_xfer) begin
      // Drained with nothing new behind it; out keeps its last value.
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (w_xfer) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // After reset each LUT entry holds the complement of its index, so LUT mode
  // behaves exactly like complement mode until software reprograms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_depth; i++) begin
        lut_q[i] <= ~WIDTH'(i);
      end
    end else begin
      lut_q <= lut_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
`default_nettype wire
